// File: rtl/rep_upload_arb.sv
// Round-robin, packet-locked arbiter that shares the reply FIFO between the mem, dcache and icache upload engines.
// Optional watchdog abort is built when REP_ARB_WATCHDOG_EN is defined.
//
// state   | meaning
// IDLE    | no grant; choose the next requester after rr_ptr
// BUSY    | one engine owns the FIFO until its last flit, request drop or watchdog
module rep_upload_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [47:0] flits_in,
    input  logic [2:0]  v_flits_in,
    input  logic [2:0]  last_in,
    input  logic        rep_fifo_rdy,
    output logic [2:0]  rdy_out,
    output logic [15:0] flit_out,
    output logic        v_flit_out,
    output logic [2:0]  grant,
    output logic        arb_state,
    output logic        arb_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;

    logic [2:0]  pick;
    logic [1:0]  g_idx;
    logic        g_req;
    logic        g_v;
    logic        g_last;
    logic [15:0] g_flit;
    logic        accept;
    logic        pkt_end;
    logic        wd_timeout;

    // Search upward from the engine after the last one served.
    always_comb begin
        pick = 3'b000;
        case (rr_ptr_q)
            2'd0: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd1: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

    // Granted-engine view; grant_q is zero in IDLE so everything here reads zero there.
    always_comb begin
        g_idx  = 2'd0;
        g_req  = 1'b0;
        g_v    = 1'b0;
        g_last = 1'b0;
        g_flit = 16'h0000;
        case (grant_q)
            3'b001: begin
                g_idx  = 2'd0;
                g_req  = req[0];
                g_v    = v_flits_in[0];
                g_last = last_in[0];
                g_flit = flits_in[15:0];
            end
            3'b010: begin
                g_idx  = 2'd1;
                g_req  = req[1];
                g_v    = v_flits_in[1];
                g_last = last_in[1];
                g_flit = flits_in[31:16];
            end
            3'b100: begin
                g_idx  = 2'd2;
                g_req  = req[2];
                g_v    = v_flits_in[2];
                g_last = last_in[2];
                g_flit = flits_in[47:32];
            end
            default: ;
        endcase
    end

    assign accept  = g_v & rep_fifo_rdy;
    assign pkt_end = accept & g_last;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick != 3'b000) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                end
            end
            ST_BUSY: begin
                // A dropped request abandons the packet silently; only the watchdog flags an error.
                if (wd_timeout || pkt_end || !g_req) begin
                    state_d  = ST_IDLE;
                    grant_d  = 3'b000;
                    rr_ptr_d = g_idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 3'b000;
            rr_ptr_q <= 2'd2;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef REP_ARB_WATCHDOG_EN
    localparam logic [3:0] TIMEOUT = 4'd15;

    logic [3:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q != ST_BUSY || accept || wd_timeout) begin
            wd_cnt_d = 4'd0;
        end else if (rep_fifo_rdy && !g_v) begin
            wd_cnt_d = wd_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= 4'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_timeout = (state_q == ST_BUSY) && (wd_cnt_q == TIMEOUT);
`else
    assign wd_timeout = 1'b0;
`endif

    assign grant      = grant_q;
    assign rdy_out    = rep_fifo_rdy ? grant_q : 3'b000;
    assign flit_out   = g_flit;
    assign v_flit_out = accept;
    assign arb_state  = (state_q == ST_BUSY);
    assign arb_err    = wd_timeout;

endmodule

// File: tb/tb_rep_upload_arb.sv
// Randomized and directed bench for rep_upload_arb against a per-packet behavioural model.
// Define REP_ARB_WATCHDOG_EN for both bench and RTL to cover the watchdog abort.
module tb_rep_upload_arb;

`ifdef REP_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [47:0] flits_in;
    logic [2:0]  v_flits_in;
    logic [2:0]  last_in;
    logic        rep_fifo_rdy;
    logic [2:0]  rdy_out;
    logic [15:0] flit_out;
    logic        v_flit_out;
    logic [2:0]  grant;
    logic        arb_state;
    logic        arb_err;

    rep_upload_arb dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .flits_in     (flits_in),
        .v_flits_in   (v_flits_in),
        .last_in      (last_in),
        .rep_fifo_rdy (rep_fifo_rdy),
        .rdy_out      (rdy_out),
        .flit_out     (flit_out),
        .v_flit_out   (v_flit_out),
        .grant        (grant),
        .arb_state    (arb_state),
        .arb_err      (arb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // engine-side packet queues: head is the flit currently offered
    logic [15:0] q_data [3][$];
    logic        q_last [3][$];
    logic [15:0] out_log [$];
    logic [2:0]  gs_grant [$];
    int          gs_cyc [$];
    int          vpct = 100;
    int          cyc = 0;
    logic [2:0]  prev_grant = 3'b000;

    // reference model: who owns the FIFO and who was served last
    int m_busy = 0;
    int m_g = 0;
    int m_rr = 2;
    int m_wd = 0;

    logic [2:0]  obs_grant, obs_rdy;
    logic [15:0] obs_flit;
    logic        obs_v, obs_state, obs_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_grant"}, 32'(grant), 32'h0);
        check_val({tag, "_rdy"},   32'(rdy_out), 32'h0);
        check_val({tag, "_flit"},  32'(flit_out), 32'h0);
        check_val({tag, "_v"},     32'(v_flit_out), 32'h0);
        check_val({tag, "_state"}, 32'(arb_state), 32'h0);
        check_val({tag, "_err"},   32'(arb_err), 32'h0);
    endtask

    task automatic push_flit(input int e, input logic [15:0] d, input logic l);
        q_data[e].push_back(d);
        q_last[e].push_back(l);
    endtask

    task automatic push_pkt(input int e, input int len, input logic [15:0] base);
        for (int j = 0; j < len; j++) push_flit(e, 16'(base + 16'(j)), (j == len - 1));
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin
            q_data[i].delete();
            q_last[i].delete();
        end
        req = 3'b000; v_flits_in = 3'b000; last_in = 3'b000;
        flits_in = 48'h0; rep_fifo_rdy = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_rr = 2; m_wd = 0;
        prev_grant = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_all();
        model_reset();
        #1;
        check_zero("rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive at the falling edge, compare just after, then advance the model.
    task automatic step(input logic fifo_rdy);
        logic [2:0]  e_grant, e_rdy;
        logic [15:0] e_flit;
        logic        e_v, e_err;
        int          nxt;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            req[i]        = (q_data[i].size() != 0);
            v_flits_in[i] = req[i] && ($urandom_range(99) < 32'(vpct));
            last_in[i]    = req[i] ? q_last[i][0] : 1'($urandom_range(1));
            flits_in[16*i +: 16] = req[i] ? q_data[i][0] : 16'($urandom);
        end
        rep_fifo_rdy = fifo_rdy;
        #1;
        e_grant = (m_busy != 0) ? 3'(1 << m_g) : 3'b000;
        e_rdy   = fifo_rdy ? e_grant : 3'b000;
        e_flit  = (m_busy != 0) ? flits_in[16*m_g +: 16] : 16'h0000;
        e_v     = (m_busy != 0) && v_flits_in[m_g] && fifo_rdy;
        e_err   = WD && (m_busy != 0) && (m_wd == 15);
        check_val("grant",      32'(grant), 32'(e_grant));
        check_val("rdy_out",    32'(rdy_out), 32'(e_rdy));
        check_val("flit_out",   32'(flit_out), 32'(e_flit));
        check_val("v_flit_out", 32'(v_flit_out), 32'(e_v));
        check_val("arb_state",  32'(arb_state), 32'(m_busy != 0));
        check_val("arb_err",    32'(arb_err), 32'(e_err));
        obs_grant = grant; obs_rdy = rdy_out; obs_flit = flit_out;
        obs_v = v_flit_out; obs_state = arb_state; obs_err = arb_err;
        if (grant != 3'b000 && prev_grant == 3'b000) begin
            gs_grant.push_back(grant);
            gs_cyc.push_back(cyc);
        end
        prev_grant = grant;
        if (e_v) begin
            out_log.push_back(q_data[m_g].pop_front());
            void'(q_last[m_g].pop_front());
        end
        if (m_busy == 0) begin
            if (req != 3'b000) begin
                nxt = -1;
                for (int k = 1; k <= 3; k++)
                    if (nxt < 0 && req[(m_rr + k) % 3]) nxt = (m_rr + k) % 3;
                m_busy = 1; m_g = nxt; m_wd = 0;
            end
        end else if (e_err || (e_v && last_in[m_g]) || !req[m_g]) begin
            m_busy = 0; m_rr = m_g;
        end else if (e_v) begin
            m_wd = 0;
        end else if (fifo_rdy) begin
            m_wd++;
        end
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int err_k;
        rst = 1'b0;
        clear_all();
        #3;
        check_zero("in_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("post_reset");

        // engine0 three-flit packet
        push_flit(0, 16'h1111, 1'b0);
        push_flit(0, 16'h2222, 1'b0);
        push_flit(0, 16'h3333, 1'b1);
        vpct = 100;
        out_log.delete();
        step(1'b1);
        check_val("t1_idle_grant", 32'(obs_grant), 32'h0);
        step(1'b1);
        check_val("t1_grant", 32'(obs_grant), 32'h1);
        check_val("t1_flit0", 32'(obs_flit), 32'h1111);
        step(1'b1);
        check_val("t1_flit1", 32'(obs_flit), 32'h2222);
        step(1'b1);
        check_val("t1_flit2", 32'(obs_flit), 32'h3333);
        check_val("t1_v2", 32'(obs_v), 32'h1);
        step(1'b1);
        check_val("t1_idle_after", 32'(obs_state), 32'h0);
        check_val("t1_count", 32'(out_log.size()), 32'd3);

        // all three engines, two 2-flit packets each
        do_reset();
        gs_grant.delete(); gs_cyc.delete();
        for (int e = 0; e < 3; e++) begin
            push_pkt(e, 2, 16'(16'h1000 * (e + 1)));
            push_pkt(e, 2, 16'(16'h1000 * (e + 1) + 16'h0100));
        end
        for (int n = 0; n < 24; n++) step(1'b1);
        check_val("t2_npkts", 32'(gs_grant.size()), 32'd6);
        if (gs_grant.size() >= 4) begin
            check_val("t2_g0", 32'(gs_grant[0]), 32'h1);
            check_val("t2_g1", 32'(gs_grant[1]), 32'h2);
            check_val("t2_g2", 32'(gs_grant[2]), 32'h4);
            check_val("t2_g3", 32'(gs_grant[3]), 32'h1);
            check_val("t2_gap", 32'(gs_cyc[1] - gs_cyc[0]), 32'd3);
        end

        // dcache packet with FIFO ready toggling
        push_pkt(1, 4, 16'hD000);
        out_log.delete();
        step(1'b1);
        for (int k = 0; k < 7; k++) begin
            step(1'((k % 2) == 0));
            check_val("t3_grant", 32'(obs_grant), 32'h2);
            check_val("t3_v", 32'(obs_v), 32'((k % 2) == 0));
        end
        step(1'b1);
        check_val("t3_idle", 32'(obs_state), 32'h0);
        check_val("t3_count", 32'(out_log.size()), 32'd4);
        for (int j = 0; j < 4 && j < out_log.size(); j++)
            check_val("t3_order", 32'(out_log[j]), 32'(16'hD000 + 16'(j)));

        // engine1 valid while engine0 owns the FIFO
        push_pkt(0, 3, 16'hA000);
        push_pkt(1, 2, 16'hB000);
        step(1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            check_val("t4_grant", 32'(obs_grant), 32'h1);
            check_val("t4_rdy1", 32'(obs_rdy[1]), 32'h0);
            check_val("t4_flit", 32'(obs_flit), 32'(16'hA000 + 16'(k)));
        end
        for (int n = 0; n < 6; n++) step(1'b1);

        // reset in the middle of the second flit
        push_pkt(0, 4, 16'hC000);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check_val("t5_pre_flit", 32'(obs_flit), 32'hC001);
        #2;
        rst = 1'b0;
        #1;
        check_zero("t5_mid_reset");
        clear_all();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        push_pkt(1, 1, 16'hE000);
        step(1'b1);
        check_val("t5_idle", 32'(obs_grant), 32'h0);
        step(1'b1);
        check_val("t5_grant", 32'(obs_grant), 32'h2);
        for (int n = 0; n < 3; n++) step(1'b1);

`ifdef REP_ARB_WATCHDOG_EN
        // icache stalls with FIFO ready: watchdog fires after 15 idle cycles
        push_pkt(2, 2, 16'hF000);
        vpct = 0;
        err_k = -1;
        step(1'b1);
        for (int k = 1; k <= 30 && err_k < 0; k++) begin
            step(1'b1);
            if (k == 1) check_val("wd_grant", 32'(obs_grant), 32'h4);
            if (obs_err) err_k = k;
        end
        check_val("wd_err_cycle", 32'(err_k), 32'd16);
        q_data[2].delete(); q_last[2].delete();
        push_pkt(0, 1, 16'h0A00);
        push_pkt(1, 1, 16'h0B00);
        vpct = 100;
        step(1'b1);
        check_val("wd_err_once", 32'(obs_err), 32'h0);
        check_val("wd_idle", 32'(obs_state), 32'h0);
        step(1'b1);
        check_val("wd_next_grant", 32'(obs_grant), 32'h1);
        for (int n = 0; n < 4; n++) step(1'b1);
`else
        err_k = 0;
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) vpct = int'($urandom_range(30, 100));
            for (int i = 0; i < 3; i++) begin
                if (q_data[i].size() == 0 && $urandom_range(99) < 15)
                    push_pkt(i, int'($urandom_range(1, 5)), 16'($urandom));
                else if (q_data[i].size() != 0 && $urandom_range(99) < 2) begin
                    q_data[i].delete();
                    q_last[i].delete();
                end
            end
            step(1'($urandom_range(99) < 75));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
